// File: rtl/spi_frame_monitor.sv
// spi_frame_monitor
//   Passive SPI frame monitor running on the SPI clock. Each frame is one
//   command cycle followed by DATA_W data bits (MSB first). Completed write and
//   read words are captured, completed frames are counted, and protocol
//   violations set sticky flags and bump a saturating error-cycle counter.
//
// Ports
//   sclk        in   SPI clock; all state updates on its rising edge
//   rst         in   asynchronous active-high reset
//   ssel        in   active-low slave selects [NUM_SS]
//   rd_wr       in   direction: 1 = write (mosi data), 0 = read (miso data)
//   mosi/miso   in   serial data, MSB first
//   err_clr     in   synchronous clear of err_flags / err_cnt
//   state       out  00 idle, 01 write, 10 read, 11 abort
//   active_ss   out  index of the select owning the current/last frame
//   rx_data     out  last completed write word
//   rd_data     out  last completed read word
//   frame_done  out  one-cycle pulse after a frame completes
//   frame_cnt   out  completed frames (wraps)
//   err_flags   out  sticky {MISO_DRIVE, RDWR_CHANGE, SHORT_FRAME, MULTI_SS}
//   err_cnt     out  cycles with at least one violation (saturates)
module spi_frame_monitor #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SS      = 1,
    parameter int unsigned FRAME_CNT_W = 16,
    parameter int unsigned ERR_CNT_W   = 8,
    parameter bit          MISO_CHK    = 1'b1,
    localparam int unsigned SS_IDX_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic [NUM_SS-1:0]      ssel,
    input  logic                   rd_wr,
    input  logic                   mosi,
    input  logic                   miso,
    input  logic                   err_clr,
    output logic [1:0]             state,
    output logic [SS_IDX_W-1:0]    active_ss,
    output logic [DATA_W-1:0]      rx_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [3:0]             err_flags,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWrite = 2'b01,
        StRead  = 2'b10,
        StAbort = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [SS_IDX_W-1:0]    active_ss_q, active_ss_d;
    logic                   dir_q, dir_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]             err_flags_q, err_flags_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [NUM_SS-1:0]   ssel_low;
    logic                any_low, one_low, multi_low;
    logic [SS_IDX_W-1:0] low_idx;
    logic                sel_high;
    logic                data_bit;
    logic [DATA_W-1:0]   shifted;
    logic [3:0]          ev;

    // One-hot test on the inverted selects: clearing the lowest set bit leaves zero.
    assign ssel_low  = ~ssel;
    assign any_low   = |ssel_low;
    assign one_low   = any_low && ((ssel_low & (ssel_low - NUM_SS'(1))) == '0);
    assign multi_low = any_low && !one_low;
    assign sel_high  = ssel[active_ss_q];
    assign data_bit  = (state_q == StWrite) ? mosi : miso;
    assign shifted   = {shreg_q[DATA_W-2:0], data_bit};

    always_comb begin
        low_idx = '0;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (!ssel[i]) low_idx = SS_IDX_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        active_ss_d  = active_ss_q;
        dir_d        = dir_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        rd_data_d    = rd_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        ev           = 4'b0000;

        unique case (state_q)
            StIdle: begin
                if (multi_low) begin
                    ev[0]   = 1'b1;
                    state_d = StAbort;
                end else if (one_low) begin
                    // Command cycle: no data bit is sampled here.
                    active_ss_d = low_idx;
                    dir_d       = rd_wr;
                    bit_cnt_d   = '0;
                    state_d     = rd_wr ? StWrite : StRead;
                end
            end
            StWrite, StRead: begin
                if (sel_high || multi_low) begin
                    // Partial word is dropped; abort wins over the data checks.
                    ev[1]   = 1'b1;
                    ev[0]   = multi_low;
                    state_d = StAbort;
                end else begin
                    shreg_d = shifted;
                    if (rd_wr != dir_q) ev[2] = 1'b1;
                    if (MISO_CHK && (state_q == StWrite) && miso) ev[3] = 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
                        if (state_q == StWrite) rx_data_d = shifted;
                        else                    rd_data_d = shifted;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                        bit_cnt_d    = '0;
                        state_d      = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            StAbort: begin
                if (!any_low) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Same-cycle events survive err_clr.
    always_comb begin
        err_flags_d = (err_clr ? 4'b0000 : err_flags_q) | ev;
        err_cnt_d   = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = ERR_CNT_W'(|ev);
        end else if ((|ev) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            active_ss_q  <= '0;
            dir_q        <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            rd_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_flags_q  <= 4'b0000;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            active_ss_q  <= active_ss_d;
            dir_q        <= dir_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            rd_data_q    <= rd_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_flags_q  <= err_flags_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign state      = state_q;
    assign active_ss  = active_ss_q;
    assign rx_data    = rx_data_q;
    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_flags  = err_flags_q;
    assign err_cnt    = err_cnt_q;

endmodule
